// File: rtl/usb4_clk_gen.sv
// Multi-channel fractional clock divider. Each channel derives a divided clock from
// local_clk; new ratios are captured into a shadow and applied at that channel's falling edge.
module usb4_clk_gen #(
    parameter int NUM_CH   = 3,
    parameter int CNT_W    = 8,
    parameter int FRAC_W   = 6,
    parameter int DEF_HALF = 2,
    parameter int DEF_FRAC = 0
) (
    input  logic                     local_clk,
    input  logic                     rst,
    input  logic [NUM_CH*CNT_W-1:0]  cfg_half,
    input  logic [NUM_CH*FRAC_W-1:0] cfg_frac,
    input  logic                     cfg_load,
    output logic [NUM_CH-1:0]        clk_out,
    output logic [NUM_CH-1:0]        tick,
    output logic                     cfg_busy
);
    localparam int CW1 = CNT_W + 1;
    localparam int FW1 = FRAC_W + 1;

    logic [NUM_CH-1:0] pendVec;

    for (genvar i = 0; i < NUM_CH; i++) begin : gChan
        logic [CNT_W-1:0]  half_q, half_d, shHalf_q, shHalf_d, cnt_q, cnt_d;
        logic [FRAC_W-1:0] frac_q, frac_d, shFrac_q, shFrac_d, acc_q, acc_d;
        logic              ext_q, ext_d, clk_q, clk_d, tick_q, tick_d, pend_q, pend_d;
        logic [CNT_W:0]    limit;
        logic [FRAC_W:0]   sum;
        logic              applyOk;

        // A fresh cfg_load in the same cycle suppresses apply so only the newest shadow is used.
        always_comb begin
            half_d   = half_q;
            frac_d   = frac_q;
            shHalf_d = shHalf_q;
            shFrac_d = shFrac_q;
            cnt_d    = cnt_q;
            acc_d    = acc_q;
            ext_d    = ext_q;
            clk_d    = clk_q;
            tick_d   = 1'b0;
            pend_d   = pend_q;
            limit    = {1'b0, half_q} - CW1'(1) + CW1'(ext_q);
            sum      = FW1'(acc_q) + FW1'(frac_q);
            applyOk  = pend_q & ~cfg_load;

            if (half_q == '0) begin
                cnt_d = '0;
                acc_d = '0;
                ext_d = 1'b0;
                clk_d = 1'b0;
                if (applyOk) begin
                    half_d = shHalf_q;
                    frac_d = shFrac_q;
                    pend_d = 1'b0;
                end
            end else if ({1'b0, cnt_q} == limit) begin
                cnt_d = '0;
                if (clk_q && applyOk) begin
                    half_d = shHalf_q;
                    frac_d = shFrac_q;
                    acc_d  = '0;
                    ext_d  = 1'b0;
                    clk_d  = 1'b0;
                    pend_d = 1'b0;
                end else begin
                    {ext_d, acc_d} = sum;
                    clk_d  = ~clk_q;
                    tick_d = ~clk_q;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if (cfg_load) begin
                shHalf_d = cfg_half[i*CNT_W +: CNT_W];
                shFrac_d = cfg_frac[i*FRAC_W +: FRAC_W];
                pend_d   = 1'b1;
            end
        end

        always_ff @(posedge local_clk or negedge rst) begin
            if (!rst) begin
                half_q   <= CNT_W'(DEF_HALF);
                frac_q   <= FRAC_W'(DEF_FRAC);
                shHalf_q <= CNT_W'(DEF_HALF);
                shFrac_q <= FRAC_W'(DEF_FRAC);
                cnt_q    <= '0;
                acc_q    <= '0;
                ext_q    <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
                pend_q   <= 1'b0;
            end else begin
                half_q   <= half_d;
                frac_q   <= frac_d;
                shHalf_q <= shHalf_d;
                shFrac_q <= shFrac_d;
                cnt_q    <= cnt_d;
                acc_q    <= acc_d;
                ext_q    <= ext_d;
                clk_q    <= clk_d;
                tick_q   <= tick_d;
                pend_q   <= pend_d;
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pendVec[i] = pend_q;
    end

    assign cfg_busy = |pendVec;

endmodule
